// File: rtl/voting_seq_ctrl.sv
// Serialized election controller: collects 2^M ballots over valid/ready, tallies per candidate,
// then scans 2^N tallies for the plurality winner. Optional win_count port via VOTING_WIN_COUNT_EN.
module voting_seq_ctrl #(
  parameter int N = 2,
  parameter int M = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         vote_valid,
  input  logic [N-1:0] vote,
  output logic         vote_ready,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] winner,
`ifdef VOTING_WIN_COUNT_EN
  output logic [M:0]   win_count,
`endif
  output logic [1:0]   state_dbg
);

  localparam int          NC          = 1 << N;
  localparam logic [M:0]  CNT_ONE     = (M+1)'(1);
  localparam logic [M:0]  LAST_BALLOT = (M+1)'(1 << M);
  localparam logic [N-1:0] IDX_ONE    = N'(1);
  localparam logic [N-1:0] LAST_IDX   = '1;

  // state_dbg encoding: 0 IDLE, 1 COLLECT, 2 SCAN, 3 DONE
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_SCAN    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t       state_q, state_d;
  logic [M:0]   tally_q [NC];
  logic [M:0]   tally_d [NC];
  logic [M:0]   count_q, count_d;
  logic [N-1:0] scan_idx_q, scan_idx_d;
  logic [N-1:0] best_idx_q, best_idx_d;
  logic [M:0]   best_cnt_q, best_cnt_d;
  logic [N-1:0] winner_q, winner_d;
  logic         cand_better;
`ifdef VOTING_WIN_COUNT_EN
  logic [M:0]   win_cnt_q, win_cnt_d;
`endif

  // Handshake: a ballot is consumed on a rising edge where vote_valid && vote_ready;
  // vote_ready is high exactly in COLLECT, and vote may change freely when vote_valid is low.
  always_comb begin
    state_d     = state_q;
    tally_d     = tally_q;
    count_d     = count_q;
    scan_idx_d  = scan_idx_q;
    best_idx_d  = best_idx_q;
    best_cnt_d  = best_cnt_q;
    winner_d    = winner_q;
    cand_better = 1'b0;
`ifdef VOTING_WIN_COUNT_EN
    win_cnt_d   = win_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_COLLECT;
          for (int i = 0; i < NC; i++) tally_d[i] = '0;
          count_d    = '0;
          scan_idx_d = '0;
          best_idx_d = '0;
          best_cnt_d = '0;
          winner_d   = '0;
`ifdef VOTING_WIN_COUNT_EN
          win_cnt_d  = '0;
`endif
        end
      end
      S_COLLECT: begin
        if (vote_valid) begin
          tally_d[vote] = tally_q[vote] + CNT_ONE;
          count_d       = count_q + CNT_ONE;
          if (count_d == LAST_BALLOT) state_d = S_SCAN;
        end
      end
      S_SCAN: begin
        // Strict compare keeps the lowest index on ties.
        cand_better = tally_q[scan_idx_q] > best_cnt_q;
        if (cand_better) begin
          best_idx_d = scan_idx_q;
          best_cnt_d = tally_q[scan_idx_q];
        end
        scan_idx_d = scan_idx_q + IDX_ONE;
        if (scan_idx_q == LAST_IDX) begin
          state_d    = S_DONE;
          scan_idx_d = '0;
          winner_d   = best_idx_d;
`ifdef VOTING_WIN_COUNT_EN
          win_cnt_d  = best_cnt_d;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NC; i++) tally_q[i] <= '0;
      count_q    <= '0;
      scan_idx_q <= '0;
      best_idx_q <= '0;
      best_cnt_q <= '0;
      winner_q   <= '0;
`ifdef VOTING_WIN_COUNT_EN
      win_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      for (int i = 0; i < NC; i++) tally_q[i] <= tally_d[i];
      count_q    <= count_d;
      scan_idx_q <= scan_idx_d;
      best_idx_q <= best_idx_d;
      best_cnt_q <= best_cnt_d;
      winner_q   <= winner_d;
`ifdef VOTING_WIN_COUNT_EN
      win_cnt_q  <= win_cnt_d;
`endif
    end
  end

  assign vote_ready = (state_q == S_COLLECT);
  assign busy       = (state_q == S_COLLECT) || (state_q == S_SCAN);
  assign done       = (state_q == S_DONE);
  assign winner     = winner_q;
  assign state_dbg  = state_q;
`ifdef VOTING_WIN_COUNT_EN
  assign win_count  = win_cnt_q;
`endif

endmodule

// File: tb/tb_voting_seq_ctrl.sv
// Bench for voting_seq_ctrl: N=2/M=2 instance plus an N=1/M=3 instance, randomized elections
// checked against a tally-and-pick reference model.
module tb_voting_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, vote_valid;
  logic [1:0] vote;
  logic       vote_ready, busy, done;
  logic [1:0] winner;
  logic [1:0] state_dbg;

  logic       start2, vote_valid2;
  logic [0:0] vote2;
  logic       vote_ready2, busy2, done2;
  logic [0:0] winner2;
  logic [1:0] state_dbg2;

`ifdef VOTING_WIN_COUNT_EN
  logic [2:0] win_count;
  logic [3:0] win_count2;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  voting_seq_ctrl #(.N(2), .M(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .vote_valid(vote_valid), .vote(vote),
    .vote_ready(vote_ready), .busy(busy), .done(done), .winner(winner),
`ifdef VOTING_WIN_COUNT_EN
    .win_count(win_count),
`endif
    .state_dbg(state_dbg)
  );

  voting_seq_ctrl #(.N(1), .M(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .vote_valid(vote_valid2), .vote(vote2),
    .vote_ready(vote_ready2), .busy(busy2), .done(done2), .winner(winner2),
`ifdef VOTING_WIN_COUNT_EN
    .win_count(win_count2),
`endif
    .state_dbg(state_dbg2)
  );

  // Reference: count ballots per candidate, plurality with lowest index on ties.
  task automatic ref_model(input int b[$], input int nc, output int w, output int c);
    int cnt[16];
    for (int i = 0; i < 16; i++) cnt[i] = 0;
    foreach (b[i]) cnt[b[i]]++;
    w = 0;
    for (int i = 1; i < nc; i++) if (cnt[i] > cnt[w]) w = i;
    c = cnt[w];
  endtask

  // Presents one ballot on dut (called #1 after an edge) and returns #1 after its handshake edge.
  task automatic drive_vote(input int v);
    int guard = 0;
    vote_valid = 1'b1;
    vote = 2'(v);
    while (!vote_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    n_cmp++;
    if (!vote_ready) begin
      n_err++;
      $display("FAIL drive_vote_timeout: vote_ready=%0b after %0d cycles, required 1", vote_ready, guard);
    end
    @(posedge clk); #1;
    vote_valid = 1'b0;
  endtask

  task automatic run_election(input string name, input int b[$], input int gaps[$],
                              input bit vote_with_start);
    int exp_w, exp_c, cyc;
    ref_model(b, 4, exp_w, exp_c);
    start = 1'b1;
    if (vote_with_start) begin
      vote_valid = 1'b1;
      vote = 2'($urandom_range(0, 3));
    end
    @(posedge clk); #1;
    start = 1'b0;
    vote_valid = 1'b0;
    n_cmp++;
    if ({done, winner, busy, vote_ready} !== {1'b0, 2'd0, 1'b1, 1'b1}) begin
      n_err++;
      $display("FAIL %s_after_start: done=%0b winner=%0d busy=%0b ready=%0b, required 0 0 1 1",
               name, done, winner, busy, vote_ready);
    end
    foreach (b[i]) begin
      if (gaps.size() > i) begin
        repeat (gaps[i]) begin
          vote_valid = 1'b0;
          vote = 2'($urandom_range(0, 3));
          @(posedge clk); #1;
        end
      end
      drive_vote(b[i]);
    end
    n_cmp++;
    if (vote_ready !== 1'b0 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL %s_ready_drop: vote_ready=%0b busy=%0b, required 0 1", name, vote_ready, busy);
    end
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cyc !== 5 || done !== 1'b1) begin
      n_err++;
      $display("FAIL %s_latency: done after %0d cycles (done=%0b), required 5", name, cyc, done);
    end
    n_cmp++;
    if (winner !== 2'(exp_w)) begin
      n_err++;
      $display("FAIL %s_winner: got %0d, required %0d", name, winner, exp_w);
    end
`ifdef VOTING_WIN_COUNT_EN
    n_cmp++;
    if (win_count !== 3'(exp_c)) begin
      n_err++;
      $display("FAIL %s_win_count: got %0d, required %0d", name, win_count, exp_c);
    end
`endif
    // Ballots offered in DONE must not disturb the held result.
    vote_valid = 1'b1;
    repeat (2) begin
      vote = 2'($urandom_range(0, 3));
      @(posedge clk); #1;
    end
    vote_valid = 1'b0;
    n_cmp++;
    if ({done, busy, vote_ready, winner} !== {1'b1, 1'b0, 1'b0, 2'(exp_w)}) begin
      n_err++;
      $display("FAIL %s_hold: done=%0b busy=%0b ready=%0b winner=%0d, required 1 0 0 %0d",
               name, done, busy, vote_ready, winner, exp_w);
    end
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({vote_ready, busy, done, winner, state_dbg} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_outputs: ready=%0b busy=%0b done=%0b winner=%0d state=%0d, required all 0",
               vote_ready, busy, done, winner, state_dbg);
    end
    n_cmp++;
    if ({vote_ready2, busy2, done2, winner2, state_dbg2} !== 6'd0) begin
      n_err++;
      $display("FAIL reset_outputs_n1m3: ready=%0b busy=%0b done=%0b winner=%0d, required all 0",
               vote_ready2, busy2, done2, winner2);
    end
  endtask

  task automatic test_basic();
    int none[$];
    run_election("basic", '{2, 2, 1, 3}, none, 1'b0);
    run_election("tie", '{3, 1, 1, 3}, none, 1'b0);
    run_election("all_zero", '{0, 0, 0, 0}, none, 1'b1);
  endtask

  task automatic test_stall();
    run_election("stall", '{1, 2, 2, 0}, '{0, 3, 0, 0}, 1'b0);
  endtask

  task automatic test_start_ignored();
    int cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_vote(1);
    drive_vote(1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || vote_ready !== 1'b1) begin
      n_err++;
      $display("FAIL start_ignored_busy: busy=%0b ready=%0b, required 1 1", busy, vote_ready);
    end
    drive_vote(3);
    start = 1'b1;
    drive_vote(3);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cyc !== 5 || winner !== 2'd1) begin
      n_err++;
      $display("FAIL start_ignored_result: latency=%0d winner=%0d, required 5 1", cyc, winner);
    end
  endtask

  task automatic test_reset_mid_scan();
    int none[$];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    drive_vote(2);
    drive_vote(2);
    drive_vote(3);
    drive_vote(2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({vote_ready, busy, done, winner, state_dbg} !== 7'd0) begin
      n_err++;
      $display("FAIL reset_mid_scan: ready=%0b busy=%0b done=%0b winner=%0d state=%0d, required all 0",
               vote_ready, busy, done, winner, state_dbg);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_election("after_reset", '{1, 1, 1, 0}, none, 1'b0);
  endtask

  task automatic test_random();
    int b[$];
    int g[$];
    for (int e = 0; e < 8; e++) begin
      b = {};
      g = {};
      for (int i = 0; i < 4; i++) begin
        b.push_back(int'($urandom_range(0, 3)));
        g.push_back(int'($urandom_range(0, 2)));
      end
      run_election($sformatf("rand%0d", e), b, g, 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_back_to_back_n1m3();
    int b[$];
    int exp_w, exp_c, cyc, guard;
    b = '{1, 0, 1, 1, 0, 0, 1, 1};
    ref_model(b, 2, exp_w, exp_c);
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    foreach (b[i]) begin
      vote_valid2 = 1'b1;
      vote2 = 1'(b[i]);
      guard = 0;
      while (!vote_ready2 && guard < 50) begin
        @(posedge clk); #1; guard++;
      end
      @(posedge clk); #1;
    end
    vote_valid2 = 1'b0;
    n_cmp++;
    if (vote_ready2 !== 1'b0) begin
      n_err++;
      $display("FAIL n1m3_ready_drop: vote_ready=%0b, required 0", vote_ready2);
    end
    cyc = 1;
    while (!done2 && cyc < 40) begin
      @(posedge clk); #1; cyc++;
    end
    n_cmp++;
    if (cyc !== 3 || winner2 !== 1'(exp_w)) begin
      n_err++;
      $display("FAIL n1m3_result: latency=%0d winner=%0d, required 3 %0d", cyc, winner2, exp_w);
    end
`ifdef VOTING_WIN_COUNT_EN
    n_cmp++;
    if (win_count2 !== 4'(exp_c)) begin
      n_err++;
      $display("FAIL n1m3_win_count: got %0d, required %0d", win_count2, exp_c);
    end
`endif
    start2 = 1'b1;
    @(posedge clk); #1;
    start2 = 1'b0;
    n_cmp++;
    if ({done2, winner2, busy2} !== {1'b0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL n1m3_restart: done=%0b winner=%0d busy=%0b, required 0 0 1", done2, winner2, busy2);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0; vote_valid = 1'b0; vote = '0;
    start2 = 1'b0; vote_valid2 = 1'b0; vote2 = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_stall();
    test_start_ignored();
    test_reset_mid_scan();
    test_random();
    test_back_to_back_n1m3();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/voting_seq_ctrl.md
Name: voting_seq_ctrl

Overview:
- Sequential controller that collects ballots one per cycle over a valid/ready handshake.
- Tallies ballots into per-candidate counters, then scans the counters to pick the plurality winner.
- Frames one election for a voting core sized 2^N candidates by 2^M voters.
- Sits between the ballot source (input sharing layer) and the result consumer; replaces the flat combinational vote bus with a serialized, counted flow.

Parameters:
- N, 2, log2 of number of candidates (2^N candidates)
- M, 2, log2 of number of voters (exactly 2^M ballots per election)

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a new election (accepted in IDLE or DONE only)
- vote_valid  in  1  ballot present on vote
- vote  in  N  candidate index of the current ballot
- vote_ready  out  1  controller can accept a ballot this cycle
- busy  out  1  election in progress (COLLECT or SCAN)
- done  out  1  result valid; held high until next start
- winner  out  N  winning candidate index; valid while done=1

Behaviour:
- Reset (async, rst_n=0): state=IDLE, all tallies=0, ballot counter=0, scan index=0. Outputs vote_ready=0, busy=0, done=0, winner=0.
- States: IDLE, COLLECT, SCAN, DONE.
- IDLE -> COLLECT on start=1.
  - Clear all tallies and the ballot counter that cycle.
  - done falls the cycle after start.
- COLLECT:
  - vote_ready=1, busy=1.
  - Handshake fires when vote_valid&vote_ready: tally[vote] += 1 and ballot counter += 1.
  - vote_valid=0 simply stalls; no timeout.
  - After the 2^M-th accepted ballot, the next state is SCAN. vote_ready drops the cycle after the last handshake.
- Widths:
  - Tallies are M+1 bits; a unanimous vote of 2^M fits without wrap.
  - Ballot counter is M+1 bits and is compared against 2^M.
  - No overflow is possible; no saturation logic.
- SCAN:
  - vote_ready=0, busy=1.
  - One candidate per cycle, index 0..2^N-1.
  - Running best starts at candidate 0; replace only when tally[i] > best (strict).
  - Tie rule: lowest index wins.
  - After index 2^N-1 is compared, go to DONE.
- DONE:
  - busy=0, done=1, winner=best index, held stable.
  - start=1 -> COLLECT with tallies cleared; done and winner drop to 0 next cycle.
- Latency: done rises exactly 2^N+1 cycles after the cycle of the final ballot handshake.
- start while busy=1: ignored, no effect on state or tallies.
- vote_valid outside COLLECT: ignored; vote_ready is 0 there.
- Simultaneous start and vote_valid in IDLE/DONE: only start acts; the ballot is not counted.
- All-zero ballots (every vote=0): winner=0.
- rst_n asserted mid-COLLECT or mid-SCAN: immediate return to IDLE with reset values. Partial tallies are discarded.

Optional Feature:
- Macro: VOTING_WIN_COUNT_EN.
- Defined: adds output port win_count (out, M+1 bits). It carries the winning tally, reset 0, valid and stable while done=1, and cleared with winner on start.
- Undefined: port absent; best-count register still exists internally for the scan comparison; no other behaviour change.

Test Plan (N=2, M=2 unless stated):
- Reset then start; ballots 2,2,1,3 one per cycle -> 4 handshakes; done rises 5 cycles after the 4th handshake; winner=2 (win_count=2 if enabled).
- Ballots 3,1,1,3 (tie) -> winner=1 (lowest index); ballots 0,0,0,0 -> winner=0, win_count=4.
- Ballots 1,2 with vote_valid low 3 cycles between them, then 2,0 -> stalls do not count; winner=2; vote_ready=0 in the cycle after the 4th handshake.
- start pulsed during COLLECT after 2 ballots, then ballots 3,3 -> start ignored; election completes after 4 ballots total with the original tallies.
- rst_n low for 1 cycle during SCAN -> all outputs 0 immediately, state IDLE; a new start with ballots 1,1,1,0 -> winner=1.
- N=1, M=3: ballots 1,0,1,1,0,0,1,1 -> winner=1 after 8 handshakes plus 3 cycles; a back-to-back start in DONE clears done next cycle.
